crc16_frame_gen: RTL
====================

Name: crc16_frame_gen

Overview:
- Transmit-side counterpart of the 64-bit CRC16 frame checker on the bus comparator path.
- Accepts a 48-bit payload and computes CRC-16/CCITT over its 6 bytes, MSB byte first.
- Emits a 64-bit frame {payload, crc} that the checker accepts as valid.
- Computes the CRC with its own internal byte-wide engine; no external CRC16D8 instance is needed.

Parameters:
- CRC_POLY, 16'h1021, generator polynomial, non-reflected, MSB-first.
- CRC_INIT, 16'hFFFF, CRC register value at the start of each frame.

Ports:
- clk  in  1  Single clock; all state updates on the falling edge of clk.
- rst  in  1  Synchronous, active-high reset.
- start  in  1  Request to build a frame; sampled only in IDLE.
- dataIn  in  48  Payload; byte 5 is [47:40] and is sent first. Latched when start is accepted.
- busy  out  1  High from the edge after start is accepted until the edge that asserts done.
- done  out  1  Single-cycle pulse: frameOut and crcValue are valid.
- frameOut  out  64  {payload[47:0], crc[15:0]}; holds its value until the next accepted start.
- crcValue  out  16  Final CRC; holds its value until the next accepted start.

Behaviour:
- Reset values, applied on a falling edge with rst=1: state=IDLE, busy=0, done=0, frameOut=64'h0, crcValue=16'h0, CRC register=CRC_INIT, byte index=0.
- Reset mid-operation aborts the frame; no done pulse is produced.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On start=1: latch dataIn into the payload register, load the CRC register with CRC_INIT, set byte index=5, set busy=1, go to CALC.
  - On start=0: stay in IDLE; done=0.
- CALC: each edge folds payload byte[index] into the CRC register as one byte-wide update (8 bit steps unrolled combinationally):
  - per bit: fb = crc[15] ^ data bit; crc = {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
  - Bytes are processed MSB byte first; within a byte, bit 7 first.
  - Index decrements each edge; after index 0 is processed, go to FINISH.
- FINISH: frameOut = {payload, crc}, crcValue = crc, done=1 for exactly this one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge N; bytes processed at edges N+1..N+6; done high after edge N+7. Throughput is one frame per 8 cycles.
- start while busy is ignored and not queued.
- start high in the same IDLE cycle in which done falls is accepted normally; back-to-back frames are allowed.
- dataIn may change freely after acceptance; only the latched copy is used.
- A held start produces a new frame every 8 cycles.
- No X values are ever driven on outputs.

Optional Feature:
- Macro: CRC16_GEN_BITSERIAL_EN.
- Defined: CALC folds one bit per edge (48 edges, bit counter 47..0) instead of one byte. done is high after edge N+49. Results are identical to byte mode.
- Undefined: byte-wide engine as described above; done after edge N+7.

Test Plan:
- rst high for 3 edges during CALC, then released -> busy=0, done=0, frameOut=0, crcValue=0; the next start completes normally.
- start with dataIn=48'h313233343536 -> done exactly 7 edges after acceptance; crcValue equals the bench reference-model CRC-CCITT(init FFFF) of those 6 bytes; frameOut[63:16]=48'h313233343536.
- Loopback: frameOut fed to the CRC16 frame checker -> crcStatus=2'b00. Corrupting frameOut bit 0 -> crcStatus=2'b01.
- start pulsed again at edges N+2 and N+5 while busy -> ignored; exactly one done pulse; result matches the first payload.
- start held high for 24 cycles with payloads 48'h0, 48'hFFFFFFFFFFFF, 48'hA5A5A5A5A5A5 -> three done pulses 8 cycles apart, each CRC matching the reference model.
- With CRC16_GEN_BITSERIAL_EN defined, repeat scenario 2 -> same crcValue; done 49 edges after acceptance.

Source files
------------

// File: rtl/crc16_frame_gen.sv
// ---------------------------------------------------------------------------
// crc16_frame_gen
//
// Transmit-side CRC-16/CCITT frame builder. A 48-bit payload is latched on an
// accepted start, the CRC is folded over its six bytes (MSB byte first,
// bit 7 first within a byte), and a 64-bit frame {payload, crc} is presented
// together with a one-cycle done pulse. The frame is accepted by the matching
// CRC16 frame checker on the bus comparator path.
//
// All state updates on the falling edge of clk; rst is synchronous and
// active-high.
//
// Optional feature (macro CRC16_GEN_BITSERIAL_EN):
//   undefined - byte-wide engine, one byte per edge, done after edge N+7.
//   defined   - bit-serial engine, one bit per edge, done after edge N+49.
//   Both produce identical results.
//
// Ports:
//   clk       in   1   clock, falling-edge active
//   rst       in   1   synchronous active-high reset
//   start     in   1   build request, sampled only in IDLE
//   dataIn    in  48   payload, [47:40] is sent first; latched on accept
//   busy      out  1   frame in progress
//   done      out  1   one-cycle pulse, frameOut/crcValue valid
//   frameOut  out 64   {payload, crc}, held until the next accepted start
//   crcValue  out 16   final CRC, held until the next accepted start
// ---------------------------------------------------------------------------
module crc16_frame_gen #(
  parameter logic [15:0] CRC_POLY = 16'h1021,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dataIn,
  output logic        busy,
  output logic        done,
  output logic [63:0] frameOut,
  output logic [15:0] crcValue
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

`ifdef CRC16_GEN_BITSERIAL_EN
  localparam int unsigned    IDX_W    = 6;
  localparam logic [IDX_W-1:0] IDX_LAST = 6'd47;  // bit index of payload MSB
`else
  localparam int unsigned    IDX_W    = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = 3'd5;   // byte index of payload MSB
`endif

  state_t             state;
  logic [47:0]        payload;
  logic [15:0]        crc;
  logic [15:0]        crc_next;
  logic [IDX_W-1:0]   idx;

  // One MSB-first CRC step for a single data bit.
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

`ifdef CRC16_GEN_BITSERIAL_EN
  always_comb begin
    crc_next = crc_bit(crc, payload[idx]);
  end
`else
  logic [7:0] cur_byte;

  assign cur_byte = payload[{idx, 3'b000} +: 8];

  // NOTE: combinational blocks use blocking '=' so each unrolled bit step
  // sees the result of the previous one; crc_next is assigned first so no
  // latch can be inferred.
  always_comb begin
    crc_next = crc;
    for (int i = 7; i >= 0; i--) begin
      crc_next = crc_bit(crc_next, cur_byte[i]);
    end
  end
`endif

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(negedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      frameOut <= 64'h0;
      crcValue <= 16'h0;
      crc      <= CRC_INIT;
      idx      <= '0;
      payload  <= 48'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            payload <= dataIn;
            crc     <= CRC_INIT;
            idx     <= IDX_LAST;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          crc <= crc_next;
          if (idx == '0) begin
            state <= FINISH;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        FINISH: begin
          frameOut <= {payload, crc};
          crcValue <= crc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
